mem_window_writer: RTL
======================

MEM_WINDOW_WRITER -- requirements
Module: mem_window_writer

Interface
REQ-001 Parameter DATA_W, default 16: width of write data.
REQ-002 Parameter ADDR_W, default 12: width of start_addr.
REQ-003 Parameter MEM_AW, default 9: width of mem_addr (512-word memory).
REQ-004 Parameter WIN_LO, default 128: lowest legal window address.
REQ-005 Parameter WIN_HI, default 255: highest legal window address.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-007 clock  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  request to begin a burst.
REQ-010 start_addr  input  ADDR_W  first address of the burst.
REQ-011 din_valid  input  1  din holds a valid word.
REQ-012 din  input  DATA_W  data word to write.
REQ-013 din_ready  output  1  block accepts din this cycle.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_addr  output  MEM_AW  memory write address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 busy  output  1  burst in progress (state not IDLE).
REQ-018 done  output  1  one-cycle pulse marking the final write of a burst.
REQ-019 OutOfBound  output  1  last start was rejected as outside [WIN_LO, WIN_HI].
REQ-020 wr_count  output  8  number of words written in the current or last burst.

Function
REQ-021 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-022 In IDLE, a start with WIN_LO <= start_addr <= WIN_HI SHALL:
- load the address counter with start_addr;
- clear wr_count and OutOfBound;
- go to WRITE.
REQ-023 In IDLE, a start with start_addr < WIN_LO or start_addr > WIN_HI SHALL set OutOfBound on the next edge.
- The FSM stays in IDLE.
- No write occurs and done stays 0.
REQ-024 start SHALL be ignored in WRITE and DONE.
REQ-025 din_ready SHALL be 1 exactly when the state is WRITE; it is decoded from registered state.
REQ-026 A handshake SHALL occur on a rising edge where din_valid and din_ready are both 1.
REQ-027 Each handshake SHALL register, for the following cycle only:
- mem_we = 1;
- mem_addr = the current address counter (low MEM_AW bits);
- mem_wdata = din.
- Write latency from handshake edge is 1 cycle.
REQ-028 Each handshake SHALL increment wr_count by 1.
REQ-029 On a handshake with address counter != WIN_HI, the counter SHALL increment by 1 and the state SHALL remain WRITE.
REQ-030 On a handshake with address counter == WIN_HI, the state SHALL go to DONE and done SHALL be registered to 1.
- done is therefore coincident with the final mem_we.
- The counter SHALL NOT wrap past WIN_HI.
REQ-031 Cycles in WRITE with din_valid = 0 SHALL leave mem_we = 0 and all state unchanged; there is no timeout.
REQ-032 DONE SHALL last exactly one cycle, then the state SHALL return to IDLE with done = 0.
REQ-033 A start sampled in the same cycle the state returns to IDLE SHALL be honoured.
REQ-034 OutOfBound SHALL hold until the next accepted start or reset.
REQ-035 wr_count SHALL hold its value in IDLE.
- Maximum value is WIN_HI - WIN_LO + 1 = 128.
REQ-036 busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.

Reset
REQ-037 Asserting reset SHALL immediately, without a clock edge:
- force the state to IDLE;
- clear mem_we, mem_addr, mem_wdata, done, OutOfBound, wr_count and the address counter to 0;
- drive din_ready and busy to 0.
REQ-038 Reset asserted mid-burst SHALL abort the burst with no further writes; the next accepted start SHALL behave as from power-up.

Verification
REQ-039 start, start_addr = 5 -> next cycle OutOfBound = 1, busy = 0, no mem_we, done = 0.
REQ-040 start, start_addr = 300 -> OutOfBound = 1, no write. A following start with start_addr = 200 -> OutOfBound = 0, busy = 1.
REQ-041 start, start_addr = 255; one word din = 16'hBEEF -> single mem_we with mem_addr = 255 and mem_wdata = BEEF, done = 1 in that cycle, wr_count = 1, then IDLE.
REQ-042 start, start_addr = 252; words 1, 2, 3, 4 with din_valid gaps of 0, 2 and 1 cycles -> writes to 252..255 with data 1..4, done only with the 4th write, wr_count = 4.
REQ-043 start, start_addr = 128; reset asserted after 3 handshakes (counter = 131) -> all outputs 0 at once, no further mem_we. A new start with start_addr = 250 completes 6 writes, 250..255.
REQ-044 start pulsed while in WRITE, with start_addr = 5 -> ignored: OutOfBound stays 0 and the address sequence is undisturbed.

Source files
------------

// File: rtl/mem_window_writer.sv
// Burst writer: accepts a start address inside [WIN_LO, WIN_HI] and streams
// din words into consecutive memory addresses up to and including WIN_HI.
module mem_window_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int MEM_AW = 9,
  parameter int WIN_LO = 128,
  parameter int WIN_HI = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              OutOfBound,
  output logic [7:0]        wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LO_A = ADDR_W'(WIN_LO);
  localparam logic [ADDR_W-1:0] HI_A = ADDR_W'(WIN_HI);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              oob_q, oob_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;

  logic in_window;
  logic handshake;
  logic at_last;

  assign in_window = (start_addr >= LO_A) && (start_addr <= HI_A);
  assign handshake = din_valid && din_ready;
  assign at_last   = (addr_q == HI_A);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && in_window) state_d = WRITE;
      WRITE:   if (handshake && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    din_ready = (state_q == WRITE);
    busy      = (state_q != IDLE);
  end

  // Datapath next values; address and data outputs hold between writes
  always_comb begin
    addr_d      = addr_q;
    wr_count_d  = wr_count_q;
    oob_d       = oob_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    if (state_q == IDLE && start) begin
      if (in_window) begin
        addr_d     = start_addr;
        wr_count_d = 8'd0;
        oob_d      = 1'b0;
      end else begin
        oob_d = 1'b1;
      end
    end
    if (state_q == WRITE && handshake) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q[MEM_AW-1:0];
      mem_wdata_d = din;
      wr_count_d  = wr_count_q + 8'd1;
      // The counter stops at WIN_HI; the final word raises done instead
      if (at_last) begin
        done_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      wr_count_q  <= '0;
      oob_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wr_count_q  <= wr_count_d;
      oob_q       <= oob_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign OutOfBound = oob_q;
  assign wr_count   = wr_count_q;

endmodule
